// File: rtl/scan_pkg.sv
// Shared definitions for the scan sequencer and the scan buffer it feeds.
package scan_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StScan  = 3'd1,
    StFull  = 3'd2,
    StXfer  = 3'd3,
    StFlush = 3'd4
  } state_t;

  localparam int unsigned DEPTH_DEFAULT   = 10;
  localparam int unsigned CNT_W_DEFAULT   = 4;
  localparam int unsigned TIMEOUT_DEFAULT = 1000;

endpackage

// File: rtl/scan_timer.sv
// Up-counter with synchronous clear and enable; flags when it sits at TERMINAL.
module scan_timer #(
  parameter int unsigned WIDTH    = 10,
  parameter int unsigned TERMINAL = 999
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [WIDTH-1:0] r_count;
  logic             w_tc;

  assign w_tc = (r_count == WIDTH'(TERMINAL));
  assign o_tc = w_tc;

  // Holds at the terminal count instead of wrapping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && !w_tc) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// Control stage for the scan buffer: fill, full-wait with timeout, read-out and clear.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int unsigned DEPTH   = DEPTH_DEFAULT,
  parameter int unsigned CNT_W   = CNT_W_DEFAULT,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [7:0]       i_sample_in,
  input  logic             i_sample_valid,
  input  logic             i_xfer_req,
  input  logic             i_abort,
  output logic [7:0]       o_data_out,
  output logic             o_scanning,
  output logic             o_transfer,
  output logic             o_flush,
  output logic             o_buf_full,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_fill
);

  localparam int unsigned      TMR_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] FILL_LST = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FILL_ONE = CNT_W'(1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_fill, w_fill_nxt;
  logic [7:0]       r_data, w_data_nxt;
  logic             r_scanning, w_scanning_nxt;
  logic             r_transfer, r_flush, r_buf_full, r_busy;
  logic             w_tmr_tc;

  scan_timer #(
    .WIDTH    (TMR_W),
    .TERMINAL (TIMEOUT - 1)
  ) u_timer (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (r_state != StFull),
    .i_en  (r_state == StFull),
    .o_tc  (w_tmr_tc)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_fill_nxt     = r_fill;
    w_data_nxt     = r_data;
    w_scanning_nxt = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start && !i_abort) begin
          w_state_nxt = StScan;
          w_fill_nxt  = '0;
        end
      end
      StScan: begin
        if (i_abort) begin
          w_state_nxt = StFlush;
        end else if (i_sample_valid) begin
          w_data_nxt     = i_sample_in;
          w_scanning_nxt = 1'b1;
          if (r_fill != FILL_MAX) w_fill_nxt = r_fill + 1'b1;
          if (r_fill == FILL_LST) w_state_nxt = StFull;
        end
      end
      StFull: begin
        if (i_abort)        w_state_nxt = StFlush;
        else if (i_xfer_req) w_state_nxt = StXfer;
        else if (w_tmr_tc)   w_state_nxt = StFlush;
      end
      StXfer: begin
        if (i_abort) begin
          w_state_nxt = StFlush;
        end else begin
          if (r_fill != '0) w_fill_nxt = r_fill - 1'b1;
          if (r_fill <= FILL_ONE) w_state_nxt = StFlush;
        end
      end
      // Already clearing, so an abort here needs no second pulse.
      StFlush: w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
    if (w_state_nxt == StFlush) w_fill_nxt = '0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_fill     <= '0;
      r_data     <= 8'h00;
      r_scanning <= 1'b0;
      r_transfer <= 1'b0;
      r_flush    <= 1'b0;
      r_buf_full <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fill     <= w_fill_nxt;
      r_data     <= w_data_nxt;
      r_scanning <= w_scanning_nxt;
      r_transfer <= (w_state_nxt == StXfer);
      r_flush    <= (w_state_nxt == StFlush);
      r_buf_full <= (w_state_nxt == StFull);
      r_busy     <= (w_state_nxt != StIdle);
    end
  end

  assign o_data_out = r_data;
  assign o_scanning = r_scanning;
  assign o_transfer = r_transfer;
  assign o_flush    = r_flush;
  assign o_buf_full = r_buf_full;
  assign o_busy     = r_busy;
  assign o_fill     = r_fill;

endmodule

// File: tb/tb_scan_sequencer.sv
// Scoreboard bench: drivers queue expected strobe events, a negedge monitor pops and compares.
module tb_scan_sequencer;

  localparam int EV_SCAN  = 0;
  localparam int EV_XFER  = 1;
  localparam int EV_FLUSH = 2;

  typedef struct {
    int kind;
    int data;
    int fill;
    int full;
    int cyc;
  } ev_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic       xfer_req;
  logic       abort;
  logic [7:0] data_out;
  logic       scanning;
  logic       transfer;
  logic       flush;
  logic       buf_full;
  logic       busy;
  logic [3:0] fill;

  ev_t sb[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;

  scan_sequencer #(
    .DEPTH   (10),
    .CNT_W   (4),
    .TIMEOUT (8)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .i_sample_in    (sample_in),
    .i_sample_valid (sample_valid),
    .i_xfer_req     (xfer_req),
    .i_abort        (abort),
    .o_data_out     (data_out),
    .o_scanning     (scanning),
    .o_transfer     (transfer),
    .o_flush        (flush),
    .o_buf_full     (buf_full),
    .o_busy         (busy),
    .o_fill         (fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int data, input int f, input int full, input int c);
    ev_t e;
    e.kind = kind; e.data = data; e.fill = f; e.full = full; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until busy drops; returns the cycle index of that edge or -1 on timeout.
  task automatic wait_idle(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!busy) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic monitor_event(input int kind);
    ev_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_strobe: got kind %0d at cycle %0d, expected none", kind, cyc);
    end else begin
      e = sb.pop_front();
      check("ev_kind", kind, e.kind);
      check("ev_cycle", cyc, e.cyc);
      check("ev_fill", int'(fill), e.fill);
      check("ev_buf_full", int'(buf_full), e.full);
      if (kind == EV_SCAN) check("ev_data_out", int'(data_out), e.data);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (scanning) monitor_event(EV_SCAN);
      if (transfer) monitor_event(EV_XFER);
      if (flush)    monitor_event(EV_FLUSH);
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_data_out"}, int'(data_out), 0);
    check({tag, "_scanning"}, int'(scanning), 0);
    check({tag, "_transfer"}, int'(transfer), 0);
    check({tag, "_flush"}, int'(flush), 0);
    check({tag, "_buf_full"}, int'(buf_full), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_fill"}, int'(fill), 0);
  endtask

  task automatic begin_scan(output int s0);
    start = 1'b1;
    tick();
    s0 = cyc;
    start = 1'b0;
  endtask

  initial begin
    int s0, at, f;
    rst = 1'b1; start = 1'b0; sample_in = 8'h00; sample_valid = 1'b0;
    xfer_req = 1'b0; abort = 1'b0;
    tick(); tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Back-to-back fill, then read-out; whole sequence is 23 edges.
    begin_scan(s0);
    for (int i = 1; i <= 10; i++) begin
      sample_in = 8'(i); sample_valid = 1'b1;
      push(EV_SCAN, i, i, (i == 10) ? 1 : 0, s0 + i);
      tick();
    end
    sample_valid = 1'b0;
    check("full_buf_full", int'(buf_full), 1);
    check("full_busy", int'(busy), 1);
    xfer_req = 1'b1;
    for (int k = 0; k < 10; k++) push(EV_XFER, 0, 10 - k, 0, s0 + 11 + k);
    push(EV_FLUSH, 0, 0, 0, s0 + 21);
    wait_idle(40, at);
    check("xfer_idle_cycle", at - s0, 22);
    xfer_req = 1'b0;
    tick();

    // Gapped samples, a dropped 11th sample, then the FULL timeout.
    begin_scan(s0);
    for (int i = 1; i <= 10; i++) begin
      sample_valid = 1'b0; sample_in = 8'hEE;
      tick(); tick();
      sample_valid = 1'b1; sample_in = 8'(8'hA0 + i);
      push(EV_SCAN, 8'hA0 + i, i, (i == 10) ? 1 : 0, s0 + 3 * i);
      tick();
    end
    f = cyc;
    sample_in = 8'h55;
    check("gap_buf_full", int'(buf_full), 1);
    push(EV_FLUSH, 0, 0, 0, f + 8);
    tick();
    sample_valid = 1'b0;
    check("gap_fill_held", int'(fill), 10);
    check("gap_data_held", int'(data_out), 8'hAA);
    wait_idle(30, at);
    check("timeout_idle_cycle", at - f, 9);
    check("timeout_fill", int'(fill), 0);

    // Abort mid-fill.
    begin_scan(s0);
    for (int i = 1; i <= 4; i++) begin
      sample_in = 8'(8'h30 + i); sample_valid = 1'b1;
      push(EV_SCAN, 8'h30 + i, i, 0, s0 + i);
      tick();
    end
    sample_valid = 1'b0; abort = 1'b1;
    push(EV_FLUSH, 0, 0, 0, s0 + 5);
    tick();
    abort = 1'b0;
    wait_idle(10, at);
    check("abort_idle_cycle", at - s0, 6);

    // Start together with abort in IDLE stays IDLE.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("idle_abort_busy", int'(busy), 0);
    tick();
    check("idle_abort_busy2", int'(busy), 0);
    check("idle_abort_flush", int'(flush), 0);

    // Asynchronous reset during read-out at fill 5.
    begin_scan(s0);
    for (int i = 1; i <= 10; i++) begin
      sample_in = 8'(8'h40 + i); sample_valid = 1'b1;
      push(EV_SCAN, 8'h40 + i, i, (i == 10) ? 1 : 0, s0 + i);
      tick();
    end
    sample_valid = 1'b0; xfer_req = 1'b1;
    for (int k = 0; k < 5; k++) push(EV_XFER, 0, 10 - k, 0, s0 + 11 + k);
    for (int k = 0; k < 6; k++) tick();
    check("rst_pre_fill", int'(fill), 5);
    check("rst_pre_transfer", int'(transfer), 1);
    #1 rst = 1'b1;
    #1 check_all_zero("async_rst");
    xfer_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Clean scan after reset.
    begin_scan(s0);
    for (int i = 1; i <= 2; i++) begin
      sample_in = 8'(8'h60 + i); sample_valid = 1'b1;
      push(EV_SCAN, 8'h60 + i, i, 0, s0 + i);
      tick();
    end
    sample_valid = 1'b0; abort = 1'b1;
    push(EV_FLUSH, 0, 0, 0, s0 + 3);
    tick();
    abort = 1'b0;
    wait_idle(10, at);
    check("post_rst_idle_cycle", at - s0, 4);

    tick(); tick();
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_sequencer.md
# scan_sequencer

- Upstream control stage for the 10-byte scan buffer.
- Accepts a raw sample stream and a start command.
- Presents one byte per accepted sample on `data_out` together with a single-cycle `scanning` write strobe.
- Sequences the buffer through fill, full-wait, read-out (`transfer`) and clear (`flush`), with abort and full-wait timeout handling.

## Interface
- `DEPTH`, 10, bytes per scan; equals buffer depth
- `CNT_W`, 4, width of fill counter; must hold DEPTH
- `TIMEOUT`, 1000, cycles allowed in FULL before automatic flush
- `clk` in 1: system clock, all logic on rising edge
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: begin a scan; sampled only in IDLE
- `sample_in` in 8: raw scan byte
- `sample_valid` in 1: `sample_in` valid this cycle
- `xfer_req` in 1: downstream ready to read buffer
- `abort` in 1: cancel and clear, any state
- `data_out` out 8: byte to buffer `data_in`
- `scanning` out 1: one-cycle write strobe per byte
- `transfer` out 1: buffer read-out enable
- `flush` out 1: one-cycle buffer clear
- `buf_full` out 1: DEPTH bytes stored, awaiting transfer
- `busy` out 1: state ≠ IDLE
- `fill` out CNT_W: bytes currently held in buffer

## Operation
- States: IDLE, SCAN, FULL, XFER, FLUSH. All outputs are registered.
- IDLE:
  - `start` → SCAN with `fill` cleared to 0.
- SCAN:
  - Each cycle with `sample_valid`: `data_out` ← `sample_in`, `scanning` pulses, `fill` +1.
  - On the edge that accepts byte DEPTH → FULL.
  - Cycles with `sample_valid`=0 leave everything held and `scanning`=0.
- FULL:
  - `buf_full`=1. Timeout counter runs from 0.
  - `xfer_req` → XFER.
  - Counter reaching TIMEOUT−1 without `xfer_req` → FLUSH.
- XFER:
  - `transfer`=1 for exactly DEPTH consecutive cycles.
  - `fill` decrements by 1 each of those cycles.
  - When `fill` reaches 0 → FLUSH.
  - `xfer_req` is ignored once in XFER.
- FLUSH:
  - `flush`=1 for exactly one cycle, `fill`=0, then → IDLE.
- Priority: `abort` > everything else.
  - `abort` in any non-IDLE state → FLUSH next edge.
  - `abort` in IDLE → stays IDLE, no flush.
  - `abort` together with `start` in IDLE → IDLE.
- Ignored inputs:
  - `start` outside IDLE.
  - `sample_valid` outside SCAN.
  - A sample arriving on the edge SCAN→FULL is the DEPTH-th byte; later samples are dropped.
- `fill` saturates: it never exceeds DEPTH and never underflows below 0.

## Timing
- Reset values: state IDLE, `data_out`=8'h00, `scanning`=0, `transfer`=0, `flush`=0, `buf_full`=0, `busy`=0, `fill`=0, timeout counter 0.
- Reset mid-operation: returns to IDLE immediately and asynchronously, with no flush pulse. The buffer is cleared by its own reset.
- Latency:
  - A sample accepted at edge N drives `data_out` and `scanning` during cycle N..N+1.
  - `fill` updates at the same edge.
- Handshake: `start`, `xfer_req` and `abort` are level-sampled at the rising edge; no acknowledge.
- `buf_full` rises at the same edge that produces the final `scanning` pulse. It falls on exit from FULL.
- Minimum full scan cycle with back-to-back samples, from the `start` edge back to IDLE: 1 + DEPTH + 1 (FULL, if `xfer_req` already high) + DEPTH + 1 = 23 cycles for DEPTH=10.
- Timeout: `flush` asserts TIMEOUT cycles after FULL entry.

## Structure
- Shared package `scan_pkg`: state enum encoding (IDLE=0, SCAN=1, FULL=2, XFER=3, FLUSH=4, 3 bits), default DEPTH=10, default TIMEOUT.
- The buffer module consumes the same DEPTH constant.
- Sub-module `scan_timer`: parameterised up-counter with synchronous clear, enable, and a terminal-count flag. Used for the FULL timeout.
- FSM and fill counter stay in the top module.

## Test plan
- Reset then `start`, ten samples 8'h01..8'h0A back-to-back → ten `scanning` pulses with matching `data_out`; `fill` 1..10; `buf_full` at the 10th; state FULL.
- From FULL, assert `xfer_req` → `transfer` high exactly 10 cycles, `fill` 10→0, then a single `flush` pulse, then IDLE; total 23 cycles from `start`.
- Samples with gaps (`sample_valid` every 3rd cycle) → exactly 10 `scanning` pulses. No strobe on invalid cycles. An 11th sample is dropped.
- FULL with `xfer_req` low, TIMEOUT=8 → `flush` pulses 8 cycles after FULL entry; `fill`=0; IDLE.
- `abort` after 4 samples → FLUSH next edge, one `flush` pulse, IDLE. `start` plus `abort` in IDLE stays IDLE.
- Assert `rst` during XFER at `fill`=5 → all outputs 0 asynchronously, state IDLE. A subsequent `start` begins a clean scan.
